// File: rtl/skid_buffer_async_rst.sv
// skid_buffer_async_rst: registered two-entry skid buffer between valid/ready interfaces
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data upstream;
// out_valid/out_ready/out_data downstream; stat_clr/stall_cnt only when
// SKID_BUFFER_STALL_CNT_EN is defined (stall cycle counter, saturating).
module skid_buffer_async_rst #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SKID_BUFFER_STALL_CNT_EN
  ,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stall_cnt
`endif
);
  typedef enum logic [1:0] {INIT, EMPTY, BUSY, FULL} state_t;
  state_t state;
  logic [WIDTH-1:0] skid;
  logic in_fire, out_fire;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // in_ready/out_valid are flops updated alongside state, so they always match it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INIT;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data <= RESET_VAL;
      skid <= RESET_VAL;
    end else
      case (state)
        INIT: begin
          state <= EMPTY;
          in_ready <= 1'b1;
        end
        EMPTY: if (in_fire) begin
          state <= BUSY;
          out_valid <= 1'b1;
          out_data <= in_data;
        end
        BUSY: if (in_fire & ~out_fire) begin
          state <= FULL;
          in_ready <= 1'b0;
          skid <= in_data;
        end else if (~in_fire & out_fire) begin
          state <= EMPTY;
          out_valid <= 1'b0;
        end else if (in_fire)
          out_data <= in_data;
        default: if (out_fire) begin
          state <= BUSY;
          in_ready <= 1'b1;
          out_data <= skid;
        end
      endcase
`ifdef SKID_BUFFER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)
      stall_cnt <= '0;
    else if (stat_clr)
      stall_cnt <= '0;
    else if (out_valid & ~out_ready & ~&stall_cnt)
      stall_cnt <= stall_cnt + CNT_W'(1);
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif
endmodule

// File: tb/tb_skid_buffer_async_rst.sv
// tb_skid_buffer_async_rst: directed self-checking bench for skid_buffer_async_rst
module tb_skid_buffer_async_rst;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  int checks = 0, failures = 0;
`ifdef SKID_BUFFER_STALL_CNT_EN
  logic stat_clr;
  logic [1:0] stall_cnt;
`endif
  skid_buffer_async_rst #(.WIDTH(8), .RESET_VAL(8'h5A), .CNT_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef SKID_BUFFER_STALL_CNT_EN
    ,
    .stat_clr(stat_clr),
    .stall_cnt(stall_cnt)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 8'h00;
`ifdef SKID_BUFFER_STALL_CNT_EN
    stat_clr = 1'b0;
`endif
    tick;
    tick;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h5A);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hEE;
    #1;
    check("init_in_ready", in_ready, 0);
    tick;
    check("init_no_accept_valid", out_valid, 0);
    check("empty_in_ready", in_ready, 1);
    check("empty_out_data", out_data, 8'h5A);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i);
      tick;
      check("stream_out_valid", out_valid, 1);
      check("stream_out_data", out_data, i);
      check("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick;
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h0A;
    tick;
    check("bp_a_out_data", out_data, 8'h0A);
    check("bp_a_in_ready", in_ready, 1);
    in_data = 8'h0B;
    tick;
    check("bp_full_in_ready", in_ready, 0);
    check("bp_full_out_valid", out_valid, 1);
    check("bp_full_out_data", out_data, 8'h0A);
    in_data = 8'h0C;
    tick;
    check("bp_hold_out_data", out_data, 8'h0A);
    check("bp_hold_in_ready", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    check("bp_b_out_data", out_data, 8'h0B);
    check("bp_b_out_valid", out_valid, 1);
    check("bp_b_in_ready", in_ready, 1);
    tick;
    check("bp_end_out_valid", out_valid, 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h0A;
    tick;
    in_data = 8'h0B;
    tick;
    check("ar_full_in_ready", in_ready, 0);
    check("ar_full_out_valid", out_valid, 1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_in_ready", in_ready, 0);
    check("ar_out_data", out_data, 8'h5A);
    tick;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("ar_after_out_valid", out_valid, 0);
      check("ar_after_out_data", out_data, 8'h5A);
    end
    check("ar_after_in_ready", in_ready, 1);
`ifdef SKID_BUFFER_STALL_CNT_EN
    out_ready = 1'b0;
    stat_clr = 1'b1;
    tick;
    check("cnt_clr", stall_cnt, 0);
    stat_clr = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h07;
    tick;
    in_valid = 1'b0;
    check("cnt_start", stall_cnt, 0);
    tick;
    check("cnt_1", stall_cnt, 1);
    tick;
    check("cnt_2", stall_cnt, 2);
    tick;
    check("cnt_3", stall_cnt, 3);
    tick;
    check("cnt_sat_a", stall_cnt, 3);
    tick;
    check("cnt_sat_b", stall_cnt, 3);
    stat_clr = 1'b1;
    tick;
    check("cnt_clr_prio", stall_cnt, 0);
    stat_clr = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/skid_buffer_async_rst.md
SKID_BUFFER_ASYNC_RST -- requirements
Module: skid_buffer_async_rst

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits (>=1).
REQ-002 Parameter RESET_VAL, default '0, WIDTH-bit value driven on out_data while reset is held.
REQ-003 Parameter CNT_W, default 32, stall counter width in bits (>=1); used only when the Configuration macro is defined.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  upstream data valid.
REQ-007 in_ready  output  1  block can accept; registered.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  downstream data valid; registered.
REQ-010 out_ready  input  1  downstream accepts.
REQ-011 out_data  output  WIDTH  downstream payload; registered, no combinational path from in_data.
REQ-012 stat_clr  input  1  synchronous clear of the stall counter (present only with the macro).
REQ-013 stall_cnt  output  CNT_W  stall cycle count (present only with the macro).

Function
REQ-014 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; transfers occur only on these at a rising edge.
REQ-015 States: INIT (post-reset, nothing accepted), EMPTY (no data held), BUSY (output register full), FULL (output and skid registers full).
REQ-016 INIT -> EMPTY unconditionally on the first rising edge after rst deasserts; in_ready=0 in INIT.
REQ-017 EMPTY: in_fire -> BUSY, out_data <= in_data.
REQ-018 BUSY: in_fire & ~out_fire -> FULL, skid <= in_data; ~in_fire & out_fire -> EMPTY; in_fire & out_fire -> BUSY, out_data <= in_data; neither -> hold.
REQ-019 FULL: out_fire -> BUSY, out_data <= skid; otherwise hold; in_valid ignored.
REQ-020 in_ready = 1 exactly in EMPTY and BUSY; out_valid = 1 exactly in BUSY and FULL.
REQ-021 Latency: word accepted at edge N is on out_data with out_valid=1 after edge N; sustained throughput 1 word/cycle with out_ready=1.
REQ-022 out_data and out_valid stay stable while out_valid=1 and out_ready=0.
REQ-023 Ordering is strict FIFO; no word dropped or duplicated.
REQ-024 out_ready asserted with out_valid=0 has no effect.

Reset
REQ-025 rst=1 immediately, without a clock edge, forces state INIT, in_ready=0, out_valid=0, out_data=RESET_VAL, skid=RESET_VAL.
REQ-026 Reset mid-transfer discards held data; no word is emitted after rst deasserts until a new in_fire.
REQ-027 With the macro, reset forces stall_cnt=0.

Configuration
REQ-028 Macro SKID_BUFFER_STALL_CNT_EN: when defined, stat_clr and stall_cnt exist; when undefined, both ports and all counter logic are absent and behaviour is otherwise identical.
REQ-029 With the macro, stall_cnt increments by 1 each cycle out_valid=1 and out_ready=0, saturates at 2^CNT_W-1, and stat_clr=1 loads 0 with priority over increment.

Verification
REQ-030 Reset release: rst 1->0 -> in_ready=0 for first edge, then 1; out_valid=0; out_data=RESET_VAL until first accept.
REQ-031 Streaming: in_valid=1 data 1,2,3,4 with out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, one cycle after each accept, in_ready stays 1.
REQ-032 Backpressure: send 0xA,0xB with out_ready=0 -> state FULL, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB emitted, in_ready returns 1.
REQ-033 Simultaneous in_fire & out_fire in BUSY -> state stays BUSY, out_data updates to new word, nothing lost.
REQ-034 Async reset in FULL between edges -> out_valid=0, in_ready=0 immediately; held 0xA/0xB never appear afterwards.
REQ-035 Macro defined, CNT_W=2: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt 1,2,3,3,3; stat_clr=1 same cycle as stall -> stall_cnt=0.
